// File: rtl/round_pkg.sv
// rtl/round_pkg.sv - shared FSM states, lane codes and parameter defaults for round_controller
package round_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] REST = 2'b00;
  localparam logic [1:0] L1   = 2'b01;
  localparam logic [1:0] L2   = 2'b10;
  localparam logic [1:0] L0   = 2'b11;

  localparam int DEF_TICK_INIT = 5000000;
  localparam int DEF_TICK_STEP = 500000;
  localparam int DEF_TICK_MIN  = 500000;
  localparam int DEF_X_START   = 160;
  localparam int DEF_X_RELOAD  = 48;
  localparam int DEF_EPS       = 36;
  localparam int DEF_NOTES     = 120;

  // True when the pad button mapped to this lane code was just pressed.
  function automatic logic lane_pressed(input logic [1:0] code, input logic [2:0] press);
    case (code)
      L1:      lane_pressed = press[1];
      L2:      lane_pressed = press[2];
      L0:      lane_pressed = press[0];
      default: lane_pressed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - falling-edge press detector for the active-low pad buttons
module key_edge_detect (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_n,
  output logic [2:0] press
);

  logic [2:0] key_q;

  always_ff @(posedge clk) begin
    if (reset) key_q <= 3'b111;
    else       key_q <= key_n;
  end

  assign press = key_q & ~key_n;

endmodule

// File: rtl/round_controller.sv
// rtl/round_controller.sv - note-scroll round FSM with hit/miss judgement and scoring
module round_controller
  import round_pkg::*;
#(
  parameter int TICK_INIT = DEF_TICK_INIT,
  parameter int TICK_STEP = DEF_TICK_STEP,
  parameter int TICK_MIN  = DEF_TICK_MIN,
  parameter int X_START   = DEF_X_START,
  parameter int X_RELOAD  = DEF_X_RELOAD,
  parameter int EPS       = DEF_EPS,
  parameter int NOTES     = DEF_NOTES
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic               start,
  input  logic [2*NOTES-1:0] pattern,
  input  logic [2:0]         key_n,
  output logic [8:0]         xoffset,
  output logic [9:0]         lane_code,
  output logic               hit,
  output logic               miss,
  output logic [7:0]         score,
  output logic               busy,
  output logic               done
);

  // Stream is at least 10 bits wide so lane_code always has five slots to show.
  localparam int          SW         = (2*NOTES > 10) ? 2*NOTES : 10;
  localparam logic [23:0] INIT_P     = 24'(TICK_INIT);
  localparam logic [23:0] STEP_P     = 24'(TICK_STEP);
  localparam logic [23:0] MIN_P      = 24'(TICK_MIN);
  localparam logic [24:0] CLAMP_EDGE = 25'(TICK_MIN) + 25'(TICK_STEP);
  localparam logic [8:0]  XS         = 9'(X_START);
  localparam logic [8:0]  XR         = 9'(X_RELOAD);
  localparam logic [9:0]  EPS_V      = 10'(EPS);
  localparam logic [6:0]  LAST_SLOT  = 7'(NOTES - 1);

  state_t          state;
  logic [SW-1:0]   stream;
  logic [23:0]     period;
  logic [23:0]     tick;
  logic [6:0]      slot;
  logic            judged;
  logic [2:0]      press;
  logic            step;
  logic            retire;
  logic            good_press;

  key_edge_detect u_keys (
    .clk   (CLOCK_50),
    .reset (reset),
    .key_n (key_n),
    .press (press)
  );

  assign step   = (state == ST_RUN) && (tick == 24'd0);
  assign retire = step && (xoffset == 9'd0);

  // A press landing on the retire edge of its own slot is dropped; the slot is judged a miss.
  assign good_press = (state == ST_RUN) && !retire && (stream[1:0] != REST) && !judged &&
                      ({1'b0, xoffset} < EPS_V) && lane_pressed(stream[1:0], press);

  assign lane_code = stream[9:0];
  assign busy      = (state == ST_LOAD) || (state == ST_RUN);
  assign done      = (state == ST_DONE);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state   <= ST_IDLE;
      stream  <= '0;
      xoffset <= XS;
      period  <= INIT_P;
      tick    <= INIT_P;
      slot    <= '0;
      score   <= '0;
      judged  <= 1'b0;
      hit     <= 1'b0;
      miss    <= 1'b0;
    end else begin
      hit  <= good_press;
      miss <= retire && (stream[1:0] != REST) && !judged;
      if (good_press) begin
        judged <= 1'b1;
        if (score != 8'hFF) score <= score + 8'd1;
      end
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) state <= ST_LOAD;
        end
        ST_LOAD: begin
          stream  <= SW'(pattern);
          xoffset <= XS;
          period  <= INIT_P;
          tick    <= INIT_P;
          slot    <= '0;
          score   <= '0;
          judged  <= 1'b0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          if (step) begin
            tick <= period;
            if (retire) begin
              stream  <= stream >> 2;
              slot    <= slot + 7'd1;
              xoffset <= XR;
              judged  <= 1'b0;
              period  <= ({1'b0, period} >= CLAMP_EDGE) ? (period - STEP_P) : MIN_P;
              if (slot == LAST_SLOT) state <= ST_DONE;
            end else begin
              xoffset <= xoffset - 9'd1;
            end
          end else begin
            tick <= tick - 24'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// tb/tb_round_controller.sv - scoreboard bench for round_controller against a queue-based round model
module tb_round_controller;

  localparam int NOTES = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [2:0] key_n = 3'b111;
  logic [8:0] xoffset;
  logic [9:0] lane_code;
  logic       hit;
  logic       miss;
  logic [7:0] score;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  round_controller #(
    .TICK_INIT(4), .TICK_STEP(1), .TICK_MIN(2), .X_START(6),
    .X_RELOAD(3), .EPS(2), .NOTES(NOTES)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .pattern(pattern), .key_n(key_n),
    .xoffset(xoffset), .lane_code(lane_code), .hit(hit), .miss(miss),
    .score(score), .busy(busy), .done(done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_hit;
    int score;
    int at;
  } ev_t;
  ev_t sb[$];
  int  hit_cnt = 0;
  int  miss_cnt = 0;
  int  miss_at[$];

  // Round model: 0 idle, 1 load, 2 run, 3 done; pending notes kept as a code queue.
  int         m_state;
  int         m_x, m_cnt, m_period, m_slot, m_score;
  bit         m_judged;
  int         m_codes[$];
  logic [2:0] m_prev;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  function automatic int key_of(input int code);
    case (code)
      1: return 1;
      2: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int exp_lane();
    int v = 0;
    for (int i = 0; i < 5 && i < m_codes.size(); i++) v |= m_codes[i] << (2 * i);
    return v;
  endfunction

  task automatic model_reset();
    m_state = 0; m_x = 6; m_cnt = 4; m_period = 4; m_slot = 0; m_score = 0;
    m_judged = 0; m_codes.delete(); m_prev = 3'b111;
  endtask

  task automatic model_step();
    logic [2:0] pr;
    int         code;
    bit         ret;
    pr = m_prev & ~key_n;
    m_prev = key_n;
    if (reset) begin
      model_reset();
      return;
    end
    case (m_state)
      0, 3: if (start) m_state = 1;
      1: begin
        m_codes.delete();
        for (int i = 0; i < NOTES; i++) m_codes.push_back(int'((pattern >> (2 * i)) & 8'h03));
        m_x = 6; m_period = 4; m_cnt = 4; m_slot = 0; m_score = 0; m_judged = 0;
        m_state = 2;
      end
      2: begin
        code = (m_codes.size() > 0) ? m_codes[0] : 0;
        ret = (m_cnt == 0) && (m_x == 0);
        if (!ret && code != 0 && !m_judged && m_x < 2 && pr[key_of(code)]) begin
          m_judged = 1;
          if (m_score < 255) m_score++;
          sb.push_back('{1'b1, m_score, cyc + 1});
        end
        if (m_cnt == 0) begin
          m_cnt = m_period;
          if (m_x > 0) m_x--;
          else begin
            if (code != 0 && !m_judged) sb.push_back('{1'b0, m_score, cyc + 1});
            void'(m_codes.pop_front());
            m_slot++;
            m_x = 3;
            m_judged = 0;
            m_period = (m_period - 1 < 2) ? 2 : m_period - 1;
            if (m_slot == NOTES) m_state = 3;
          end
        end else begin
          m_cnt--;
        end
      end
      default: m_state = 0;
    endcase
  endtask

  task automatic tick(input logic r, input logic s, input logic [2:0] k);
    reset = r; start = s; key_n = k;
    model_step();
    @(posedge clk);
    #1;
    chk("xoffset", int'(xoffset), m_x);
    chk("lane_code", int'(lane_code), exp_lane());
    chk("score", int'(score), m_score);
    chk("busy", int'(busy), int'(m_state == 1 || m_state == 2));
    chk("done", int'(done), int'(m_state == 3));
  endtask

  task automatic wait_run(input int x, input bit at_retire, input string name);
    int n = 0;
    while (!(m_state == 2 && m_x == x && (!at_retire || m_cnt == 0)) && n < 500) begin
      tick(1'b0, 1'b0, 3'b111);
      n++;
    end
    if (n >= 500) bound_fail(name);
  endtask

  task automatic run_to_done(input string name);
    int n = 0;
    while (m_state != 3 && n < 500) begin
      tick(1'b0, 1'b0, 3'b111);
      n++;
    end
    if (n >= 500) bound_fail(name);
    tick(1'b0, 1'b0, 3'b111);
  endtask

  // Scoreboard monitor: every hit/miss pulse must match the next expected event on its cycle.
  always @(negedge clk) begin
    ev_t e;
    if (hit) hit_cnt++;
    if (miss) begin
      miss_cnt++;
      miss_at.push_back(cyc);
    end
    if (hit || miss) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL pulse actual=hit%0b/miss%0b@%0d expected=none", hit, miss, cyc);
      end else begin
        e = sb.pop_front();
        if (hit != e.is_hit || miss != !e.is_hit || int'(score) != e.score || cyc != e.at) begin
          failures++;
          $display("FAIL pulse actual=hit%0b/miss%0b/score%0d@%0d expected=hit%0b/score%0d@%0d",
                   hit, miss, score, cyc, e.is_hit, e.score, e.at);
        end
      end
    end else if (sb.size() > 0 && sb[0].at <= cyc) begin
      checks++;
      failures++;
      e = sb.pop_front();
      $display("FAIL pulse actual=none@%0d expected=hit%0b@%0d", cyc, e.is_hit, e.at);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int h0, m0, done_at, want;
    logic [2:0] k;
    model_reset();
    tick(1'b1, 1'b0, 3'b111);
    tick(1'b1, 1'b0, 3'b111);
    chk("rst_xoffset", int'(xoffset), 6);
    chk("rst_lane", int'(lane_code), 0);
    chk("rst_hit", int'(hit), 0);
    chk("rst_miss", int'(miss), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

    // No keys: slots 0-2 miss, rest slot silent, retire gaps follow periods 4,3,2,2.
    pattern = 8'b00_11_10_01;
    m0 = miss_cnt;
    miss_at.delete();
    tick(1'b0, 1'b1, 3'b111);
    wait_run(0, 1'b0, "a_run");
    while (m_state != 3 && cyc < 2000) tick(1'b0, 1'b0, 3'b111);
    done_at = cyc;
    tick(1'b0, 1'b0, 3'b111);
    chk("a_done", int'(done), 1);
    chk("a_misses", miss_cnt - m0, 3);
    chk("a_score", int'(score), 0);
    if (miss_at.size() >= 3) begin
      chk("a_gap01", miss_at[1] - miss_at[0], 17);
      chk("a_gap12", miss_at[2] - miss_at[1], 13);
      chk("a_gap2_done", done_at - miss_at[2], 12);
    end

    // Correct press at x=1 hits once; a second press in the same slot is ignored.
    pattern = 8'b00_00_00_01;
    h0 = hit_cnt; m0 = miss_cnt;
    tick(1'b0, 1'b1, 3'b111);
    wait_run(1, 1'b0, "b_x1");
    tick(1'b0, 1'b0, 3'b101);
    tick(1'b0, 1'b0, 3'b101);
    tick(1'b0, 1'b0, 3'b111);
    chk("b_hit", hit_cnt - h0, 1);
    chk("b_score", int'(score), 1);
    tick(1'b0, 1'b0, 3'b101);
    tick(1'b0, 1'b0, 3'b111);
    tick(1'b0, 1'b0, 3'b111);
    chk("b_second_press", hit_cnt - h0, 1);
    run_to_done("b_done");
    chk("b_no_miss", miss_cnt - m0, 0);
    chk("b_final_score", int'(score), 1);

    // Right key outside the window and wrong key inside it: no hit, slot misses.
    h0 = hit_cnt; m0 = miss_cnt;
    tick(1'b0, 1'b1, 3'b111);
    wait_run(3, 1'b0, "c_x3");
    tick(1'b0, 1'b0, 3'b101);
    tick(1'b0, 1'b0, 3'b111);
    wait_run(1, 1'b0, "c_x1");
    tick(1'b0, 1'b0, 3'b011);
    tick(1'b0, 1'b0, 3'b111);
    run_to_done("c_done");
    chk("c_hits", hit_cnt - h0, 0);
    chk("c_misses", miss_cnt - m0, 1);

    // Correct press on the retire edge: retire wins.
    h0 = hit_cnt; m0 = miss_cnt;
    tick(1'b0, 1'b1, 3'b111);
    wait_run(0, 1'b1, "d_retire");
    tick(1'b0, 1'b0, 3'b101);
    tick(1'b0, 1'b0, 3'b111);
    run_to_done("d_done");
    chk("d_hits", hit_cnt - h0, 0);
    chk("d_misses", miss_cnt - m0, 1);
    chk("d_score", int'(score), 0);

    // Score two hits, then reset mid-round.
    pattern = 8'h55;
    tick(1'b0, 1'b1, 3'b111);
    for (int n = 0; n < 400 && m_score < 2; n++) begin
      want = int'(m_state == 2 && m_x < 2 && !m_judged);
      k = (want != 0 && key_n == 3'b111) ? 3'b101 : 3'b111;
      tick(1'b0, 1'b0, k);
    end
    chk("e_score_before", int'(score), 2);
    chk("e_busy_before", int'(busy), 1);
    tick(1'b1, 1'b0, 3'b111);
    chk("e_rst_score", int'(score), 0);
    chk("e_rst_xoffset", int'(xoffset), 6);
    chk("e_rst_busy", int'(busy), 0);
    chk("e_rst_done", int'(done), 0);
    tick(1'b0, 1'b0, 3'b111);

    // Randomized rounds, keys, starts and rare resets against the model.
    for (int n = 0; n < 3000; n++) begin
      pattern = 8'($urandom);
      tick(($urandom % 400) == 0, ($urandom % 6) == 0,
           (($urandom % 4) == 0) ? 3'($urandom) : 3'b111);
    end
    for (int n = 0; n < 4; n++) tick(1'b0, 1'b0, 3'b111);
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/round_controller.md
ROUND_CONTROLLER -- requirements
Module: round_controller

Interface
REQ-001 SHALL have parameter TICK_INIT, default 5000000: initial clocks per scroll step.
REQ-002 SHALL have parameter TICK_STEP, default 500000: tick-period decrement applied per retired note.
REQ-003 SHALL have parameter TICK_MIN, default 500000: tick-period floor.
REQ-004 SHALL have parameter X_START, default 160: xoffset loaded at round start.
REQ-005 SHALL have parameter X_RELOAD, default 48: xoffset loaded after each retire.
REQ-006 SHALL have parameter EPS, default 36: hit window, xoffset < EPS.
REQ-007 SHALL have parameter NOTES, default 120: note slots per round.
REQ-008 SHALL have port CLOCK_50, input, 1: the only clock.
REQ-009 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-010 SHALL have port start, input, 1: level-sampled; begins a round.
REQ-011 SHALL have port pattern, input, 2*NOTES: note codes, slot 0 in bits [1:0]; sampled only in LOAD.
REQ-012 SHALL have port key_n, input, 3: active-low pad buttons.
REQ-013 SHALL have port xoffset, output, 9: x position of the current note.
REQ-014 SHALL have port lane_code, output, 10: codes of the current and next 4 slots, current in [1:0].
REQ-015 SHALL have port hit and port miss, output, 1 each: one-cycle judgement pulses.
REQ-016 SHALL have port score, output, 8: hit count.
REQ-017 SHALL have port busy and port done, output, 1 each: round active and round finished.

Function
REQ-018 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE: IDLE->LOAD on start; LOAD->RUN after 1 cycle; RUN->DONE on the retire of slot NOTES-1; DONE->LOAD on start.
REQ-019 LOAD SHALL latch pattern, set xoffset=X_START, period=TICK_INIT, tick counter=TICK_INIT, slot=0, score=0, and the judged flag=0.
REQ-020 In RUN, the tick counter SHALL decrement every cycle; at 0 it SHALL reload with period and generate one step.
REQ-021 A step SHALL decrement xoffset when xoffset>0; when xoffset==0 it SHALL retire instead.
REQ-022 A retire SHALL shift the latched stream right 2 bits (zero-fill), increment slot, set xoffset=X_RELOAD, clear judged, and set period=max(period-TICK_STEP, TICK_MIN).
REQ-023 Key press SHALL be key_n[i] 1 on the previous cycle and 0 on the current cycle; a held key SHALL yield exactly one press.
REQ-024 Lane map SHALL be: code 01 -> key_n[1], 10 -> key_n[2], 11 -> key_n[0], 00 = rest (no key).
REQ-025 hit SHALL pulse the cycle after a press of the mapped key while in RUN, code!=00, judged==0, and xoffset<EPS; the same edge SHALL set judged=1 and score=min(score+1,255).
REQ-026 A press of the wrong key, a press outside the window, or a press with judged==1 SHALL be ignored and SHALL NOT cause hit or miss.
REQ-027 miss SHALL pulse the cycle after a retire of a slot with code!=00 and judged==0.
REQ-028 On a press in the window coincident with the retire of the same slot, the retire SHALL take priority: the slot counts as a miss and the press SHALL be ignored.
REQ-029 busy SHALL be 1 in LOAD and RUN; done SHALL be 1 only in DONE.
REQ-030 score and lane_code SHALL hold their values in DONE; start SHALL be ignored in LOAD and RUN.
REQ-031 Width rules: period and tick counter SHALL be 24 bits; slot counter SHALL be 7 bits; TICK_STEP subtraction SHALL clamp with no underflow wrap.

Reset
REQ-032 reset SHALL take priority over all inputs and return the FSM to IDLE on the next edge, including mid-round.
REQ-033 On reset, outputs SHALL be: xoffset=X_START, lane_code=0, hit=0, miss=0, score=0, busy=0, done=0; key history SHALL be all 1s.

Structure
REQ-034 Package round_pkg SHALL hold the state enum, lane-code constants (REST=00, L1=01, L2=10, L0=11), and default parameter values.
REQ-035 Edge detection SHALL be a sub-module key_edge_detect (3-bit, registered, synchronous reset to 1s); everything else SHALL be in round_controller.

Verification (TICK_INIT=4, TICK_STEP=1, TICK_MIN=2, X_START=6, X_RELOAD=3, EPS=2, NOTES=4)
REQ-036 Reset mid-RUN with score=2 SHALL give IDLE, score=0, and xoffset=6 on the next cycle.
REQ-037 Pattern 8'b00_11_10_01 with start and no keys SHALL give miss pulses on slots 0-2, no pulse on slot 3, done=1, and score=0.
REQ-038 Slot 0 code 01 with key_n[1] falling at xoffset=1 SHALL give hit the next cycle, score=1, and a second press of the same key SHALL give no hit.
REQ-039 Slot 0 code 01 with key_n[2] press at xoffset=1 SHALL give no hit and a miss at retire; a key_n[1] press at xoffset=3 SHALL give no hit.
REQ-040 The retire period sequence SHALL be 4, 3, 2, 2 (clamped at TICK_MIN).
REQ-041 A correct press at xoffset=0 on the same cycle as the retire SHALL give a miss, no hit, and score unchanged.
